level_bcd_processor: RTL and testbench
======================================

Name: level_bcd_processor

Overview:
- Upstream stage of the display controller. Captures a binary liquid-level sample on a strobe and range-checks it.
- Converts the sample to three BCD digits (hundreds/tens/units) with a sequential shift-add-3 engine.
- Compares the sample against high/low thresholds.
- Presents data_h/data_t/data_u, GOET, LOET and input_error as registered outputs that update atomically once per conversion.

Parameters:
- WIDTH, 10, bit width of level_in, high_thr and low_thr.
- MAX_LEVEL, 999, largest valid level; must be at most 999 so the result fits three BCD digits.

Ports:
- clk_100MHz  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sample_en  input  1  single-cycle strobe requesting a new conversion.
- level_in  input  WIDTH  unsigned binary level sample.
- high_thr  input  WIDTH  upper alarm threshold.
- low_thr  input  WIDTH  lower alarm threshold.
- data_h  output  4  BCD hundreds digit.
- data_t  output  4  BCD tens digit.
- data_u  output  4  BCD units digit.
- GOET  output  1  level greater than or equal to high_thr.
- LOET  output  1  level less than or equal to low_thr.
- input_error  output  1  sample out of range, or thresholds inconsistent.
- busy  output  1  conversion in progress.
- valid  output  1  one-cycle pulse when outputs commit.

Behaviour:
- Interface (already decided): one clock, clk_100MHz; reset is synchronous and active-high. No other clocks; no asynchronous logic.
- Reset: state IDLE; data_h/t/u = 0; GOET = LOET = input_error = 0; busy = valid = 0; internal shift and BCD registers cleared.
- A reset asserted mid-conversion aborts it. No valid pulse is produced, and outputs take their reset values on that edge.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE, sample_en = 1 at edge k:
  - Capture level_in, high_thr and low_thr into shadow registers.
  - Clear the 12-bit BCD accumulator and the iteration counter.
  - Go to SHIFT; busy = 1 from edge k.
- SHIFT, one iteration per cycle for exactly WIDTH cycles (edges k+1 .. k+WIDTH):
  - Each BCD nibble that is >= 5 gets +3.
  - Then shift {bcd, bin} left by one bit.
  - Counter wraps from WIDTH-1 to 0; on that transition go to COMMIT.
- COMMIT, edge k+WIDTH+1 (k+11 at default):
  - Write data_h/t/u, GOET, LOET and input_error together.
  - valid = 1 for exactly one cycle; busy = 0; return to IDLE.
- Latency from the strobe edge to outputs visible is WIDTH+1 cycles (11 at default). The earliest accepted restart is the cycle after COMMIT.
- sample_en while busy = 1 is ignored and not queued. sample_en in the COMMIT cycle is also ignored.
- Between commits all outputs hold their values; they never show partial results.
- Range rule, using shadow values:
  - When level > MAX_LEVEL: input_error = 1, digits saturate to 9/9/9, GOET = 1, LOET = 0.
  - When low_thr >= high_thr: input_error = 1, digits show the converted level (or 9/9/9 if the level is also out of range), GOET = LOET = 0.
  - Otherwise input_error = 0, and GOET/LOET follow unsigned compares (level >= high_thr, level <= low_thr).
- GOET and LOET are never both 1.
- All compares are unsigned at full WIDTH. The BCD adjust is done per nibble at 4 bits with no carry between nibbles.
- Thresholds are sampled only at the strobe. Changes during a conversion affect only the next conversion.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE/SHIFT/COMMIT, 2 bits);
  - BCD_DIGITS = 3 and BCD_W = 12;
  - the constant 4'd9 used as the saturation digit.
- One sub-module is natural: bcd_add3_adjust, a combinational 12-bit block that applies the per-nibble "if >= 5 add 3" step. It is instantiated once in the SHIFT datapath.

Test Plan:
- Reset released, no strobe, 50 cycles -> all outputs 0, busy = 0, valid never 1. Mid-conversion reset at cycle k+5 -> no valid pulse, digits 0.
- level 537, low 100, high 900, strobe at edge k -> busy 1 over edges k..k+10; valid pulse at k+11; digits 5/3/7; GOET = LOET = input_error = 0.
- level 0, low 100, high 900 -> digits 0/0/0, LOET = 1; then level 900 -> digits 9/0/0, GOET = 1 (equality boundary).
- level 1023, low 100, high 900 -> input_error = 1, digits 9/9/9, GOET = 1, LOET = 0.
- level 400, low 500, high 500 -> input_error = 1, digits 4/0/0, GOET = LOET = 0.
- Strobe level 123, then strobe level 456 at k+4 (while busy) -> single valid at k+11 with 1/2/3; second strobe has no effect; a strobe at k+12 converts 456 with valid at k+23.

Source files
------------

// File: rtl/level_bcd_processor_pkg.sv
// level_bcd_processor_pkg: shared FSM encoding and BCD constants
package level_bcd_processor_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    localparam int BCD_DIGITS = 3;
    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam logic [3:0] SAT_DIGIT = 4'd9;
endpackage

// File: rtl/level_bcd_processor_bcd_add3_adjust.sv
// bcd_add3_adjust: per-nibble "if >= 5 add 3" step of the shift-add-3 conversion
module bcd_add3_adjust
    import level_bcd_processor_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_in,
    output logic [BCD_W-1:0] bcd_out
);
    for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_nib
        assign bcd_out[4*d +: 4] = bcd_in[4*d +: 4] >= 4'd5 ? bcd_in[4*d +: 4] + 4'd3 : bcd_in[4*d +: 4];
    end
endmodule

// File: rtl/level_bcd_processor.sv
// level_bcd_processor: strobed level capture, sequential binary-to-BCD conversion and threshold alarms
module level_bcd_processor
    import level_bcd_processor_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int MAX_LEVEL = 999
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] level_in,
    input  logic [WIDTH-1:0] high_thr,
    input  logic [WIDTH-1:0] low_thr,
    output logic [3:0]       data_h,
    output logic [3:0]       data_t,
    output logic [3:0]       data_u,
    output logic             GOET,
    output logic             LOET,
    output logic             input_error,
    output logic             busy,
    output logic             valid
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t state, state_next;
    logic [WIDTH-1:0] lvl, hi, lo, bin;
    logic [BCD_W-1:0] bcd, bcd_adj;
    logic [CW-1:0]    cnt;
    logic             last, oor, bad;

    bcd_add3_adjust u_adj (.bcd_in(bcd), .bcd_out(bcd_adj));

    assign last = cnt == CW'(WIDTH - 1);
    assign oor  = lvl > WIDTH'(MAX_LEVEL);
    assign bad  = lo >= hi;
    assign busy = state != IDLE;

    always_comb begin
        state_next = state;
        state_next = state == IDLE  ? (sample_en ? SHIFT : IDLE) :
                     state == SHIFT ? (last ? COMMIT : SHIFT) : IDLE;
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            lvl <= '0;
            hi <= '0;
            lo <= '0;
            bin <= '0;
            bcd <= '0;
            cnt <= '0;
            data_h <= '0;
            data_t <= '0;
            data_u <= '0;
            GOET <= 1'b0;
            LOET <= 1'b0;
            input_error <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == IDLE && sample_en) begin
                lvl <= level_in;
                hi <= high_thr;
                lo <= low_thr;
                bin <= level_in;
                bcd <= '0;
                cnt <= '0;
            end
            if (state == SHIFT) begin
                {bcd, bin} <= {bcd_adj, bin} << 1;
                cnt <= last ? '0 : cnt + CW'(1);
            end
            // threshold inconsistency suppresses both alarms even when the level is also out of range
            if (state == COMMIT) begin
                data_h <= oor ? SAT_DIGIT : bcd[11:8];
                data_t <= oor ? SAT_DIGIT : bcd[7:4];
                data_u <= oor ? SAT_DIGIT : bcd[3:0];
                GOET <= !bad && (oor || lvl >= hi);
                LOET <= !bad && !oor && lvl <= lo;
                input_error <= oor || bad;
                valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_level_bcd_processor.sv
// tb_level_bcd_processor: directed vectors checked against a cycle-level reference model and literal expectations
module tb_level_bcd_processor;
    localparam int WIDTH = 10;

    logic clk_100MHz = 1'b0;
    logic reset = 1'b1;
    logic sample_en = 1'b0;
    logic [WIDTH-1:0] level_in = '0, high_thr = '0, low_thr = '0;
    logic [3:0] data_h, data_t, data_u;
    logic GOET, LOET, input_error, busy, valid;

    int asserts = 0, failures = 0;
    bit check_en = 1'b0;
    int m_left = 0, m_lvl = 0, m_hi = 0, m_lo = 0, m_shown = 0;
    int e_h = 0, e_t = 0, e_u = 0, e_g = 0, e_l = 0, e_err = 0, e_valid = 0;
    bit m_bad, m_oor;

    level_bcd_processor #(.WIDTH(WIDTH), .MAX_LEVEL(999)) dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .sample_en(sample_en),
        .level_in(level_in), .high_thr(high_thr), .low_thr(low_thr),
        .data_h(data_h), .data_t(data_t), .data_u(data_u),
        .GOET(GOET), .LOET(LOET), .input_error(input_error),
        .busy(busy), .valid(valid)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string n, input int act, input int exp);
        asserts++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, exp);
        end
    endtask

    // Reference model: a countdown of cycles to commit, results from decimal arithmetic
    always @(posedge clk_100MHz) begin
        if (reset) begin
            m_left = 0;
            {e_h, e_t, e_u, e_g, e_l, e_err, e_valid} = '0;
        end else begin
            e_valid = 0;
            if (m_left == 1) begin
                m_oor = m_lvl > 999;
                m_bad = m_lo >= m_hi;
                m_shown = m_oor ? 999 : m_lvl;
                e_h = m_shown / 100;
                e_t = (m_shown / 10) % 10;
                e_u = m_shown % 10;
                e_err = int'(m_oor || m_bad);
                e_g = int'(!m_bad && (m_oor || m_lvl >= m_hi));
                e_l = int'(!m_bad && !m_oor && m_lvl <= m_lo);
                e_valid = 1;
                m_left = 0;
            end else if (m_left > 1) begin
                m_left--;
            end else if (sample_en) begin
                m_lvl = int'(level_in);
                m_hi = int'(high_thr);
                m_lo = int'(low_thr);
                m_left = WIDTH + 1;
            end
        end
    end

    always @(negedge clk_100MHz) begin
        if (check_en) begin
            check("busy", busy, int'(m_left > 0));
            check("valid", valid, e_valid);
            check("data_h", data_h, e_h);
            check("data_t", data_t, e_t);
            check("data_u", data_u, e_u);
            check("GOET", GOET, e_g);
            check("LOET", LOET, e_l);
            check("input_error", input_error, e_err);
        end
    end

    // Caller sits at a negedge; the strobe is sampled on the next rising edge
    task automatic strobe(input int l, input int lo, input int hi);
        level_in = WIDTH'(l);
        low_thr = WIDTH'(lo);
        high_thr = WIDTH'(hi);
        sample_en = 1'b1;
        @(negedge clk_100MHz);
        sample_en = 1'b0;
        level_in = '0;
        low_thr = '0;
        high_thr = '0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk_100MHz);
            if (valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic convert(input int l, input int lo, input int hi, input int eh, input int et,
                           input int eu, input int eg, input int el, input int ee);
        int n;
        strobe(l, lo, hi);
        wait_valid(n);
        check("latency", n, WIDTH + 1);
        check("lit_h", data_h, eh);
        check("lit_t", data_t, et);
        check("lit_u", data_u, eu);
        check("lit_GOET", GOET, eg);
        check("lit_LOET", LOET, el);
        check("lit_err", input_error, ee);
    endtask

    initial begin
        int n;
        bit seen;
        @(negedge clk_100MHz);
        check_en = 1'b1;
        @(negedge clk_100MHz);
        reset = 1'b0;
        repeat (50) @(negedge clk_100MHz);
        check("idle_busy", busy, 0);
        check("idle_h", data_h, 0);

        convert(537, 100, 900, 5, 3, 7, 0, 0, 0);

        strobe(700, 100, 900);
        repeat (4) @(negedge clk_100MHz);
        reset = 1'b1;
        @(negedge clk_100MHz);
        reset = 1'b0;
        check("abort_h", data_h, 0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk_100MHz);
            if (valid) seen = 1'b1;
        end
        check("abort_no_valid", int'(seen), 0);

        convert(0, 100, 900, 0, 0, 0, 0, 1, 0);
        convert(900, 100, 900, 9, 0, 0, 1, 0, 0);
        convert(1023, 100, 900, 9, 9, 9, 1, 0, 1);
        convert(400, 500, 500, 4, 0, 0, 0, 0, 1);
        convert(999, 998, 999, 9, 9, 9, 1, 0, 0);

        strobe(123, 100, 900);
        repeat (3) @(negedge clk_100MHz);
        strobe(456, 100, 900);
        wait_valid(n);
        check("overlap_latency", n, WIDTH + 1 - 4);
        check("overlap_h", data_h, 1);
        check("overlap_t", data_t, 2);
        check("overlap_u", data_u, 3);
        convert(456, 100, 900, 4, 5, 6, 0, 0, 0);

        repeat (3) @(negedge clk_100MHz);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
